// File: rtl/gray_sobel_edge_pkg.sv
// Shared constants and types for the gray_sobel_edge video stage.
//   IMG_HDISP_DEF/IMG_VDISP_DEF : default frame geometry
//   PIX_W / RGB_W               : luma and packed RGB widths
//   SOBEL_LAT                   : fixed input-to-output latency in cycles
//   MAG_W                       : signed gradient / unsigned magnitude width
package gray_sobel_edge_pkg;

  localparam int unsigned IMG_HDISP_DEF = 640;
  localparam int unsigned IMG_VDISP_DEF = 480;
  localparam int unsigned PIX_W         = 8;
  localparam int unsigned RGB_W         = 24;
  localparam int unsigned SOBEL_LAT     = 4;
  localparam int unsigned MAG_W         = 11;
  localparam int unsigned ROW_W         = 11;

  typedef logic [PIX_W-1:0] pix_t;

  // 3x3 window, index [row][col]; [0][0] is top-left, [2][2] is the newest pixel.
  typedef logic [2:0][2:0][PIX_W-1:0] win_t;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } timing_t;

  function automatic logic [MAG_W-1:0] abs_mag(input logic signed [MAG_W-1:0] v);
    return v[MAG_W-1] ? MAG_W'(-v) : MAG_W'(v);
  endfunction

endpackage

// File: rtl/gray_sobel_edge_if.sv
// Pixel-stream bundle for gray_sobel_edge.
//   per_frame_*  : input timing (vsync/href/clken)
//   pix_data_in  : 24-bit pixel, luma in [23:16]
//   edge_thresh  : magnitude threshold
//   post_frame_* : output timing, delayed by SOBEL_LAT
//   edge_data    : replicated edge byte {E,E,E}
// master = stream source/sink side, slave = the edge stage.
interface gray_sobel_edge_if;
  import gray_sobel_edge_pkg::*;

  logic             per_frame_vsync;
  logic             per_frame_href;
  logic             per_frame_clken;
  logic [RGB_W-1:0] pix_data_in;
  logic [MAG_W-1:0] edge_thresh;
  logic             post_frame_vsync;
  logic             post_frame_href;
  logic             post_frame_clken;
  logic [RGB_W-1:0] edge_data;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, pix_data_in, edge_thresh,
    input  post_frame_vsync, post_frame_href, post_frame_clken, edge_data
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, pix_data_in, edge_thresh,
    output post_frame_vsync, post_frame_href, post_frame_clken, edge_data
  );

endinterface

// File: rtl/gray_sobel_edge_matrix.sv
// 3x3 luma window generator built from two line buffers.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   i_vsync/i_href/i_clken : input timing; a pixel is taken on href&clken
//   i_y      : luma of the current pixel
//   o_win    : window taps, [2][2] = current pixel (x,y), [1][1] = (x-1,y-1)
//   o_acc    : accept strobe delayed one cycle (window valid)
//   o_border : window touches col<2, row<2 or an over-length pixel
module gray_sobel_edge_matrix
  import gray_sobel_edge_pkg::*;
#(
  parameter int unsigned IMG_HDISP = IMG_HDISP_DEF,
  parameter int unsigned IMG_VDISP = IMG_VDISP_DEF,
  parameter int unsigned LB_AW     = 10
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_vsync,
  input  logic i_href,
  input  logic i_clken,
  input  pix_t i_y,
  output win_t o_win,
  output logic o_acc,
  output logic o_border
);

  logic             w_acc;
  logic             w_href_fall;
  logic             w_lb_we;
  logic             r_href_d;
  logic [LB_AW-1:0] r_col;
  logic             r_col_full;  // last column consumed; further pixels are over-length
  logic [ROW_W-1:0] r_row;
  win_t             r_win;
  logic             r_acc;
  logic             r_border;
  pix_t             r_lb0 [IMG_HDISP];
  pix_t             r_lb1 [IMG_HDISP];
  pix_t             w_lb0_rd;
  pix_t             w_lb1_rd;

  assign w_acc       = i_href & i_clken;
  assign w_href_fall = r_href_d & ~i_href;
  // Over-length pixels never touch memory so the saturated address is not corrupted.
  assign w_lb_we     = w_acc & ~r_col_full;
  assign w_lb0_rd    = r_lb0[r_col];
  assign w_lb1_rd    = r_lb1[r_col];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_href_d   <= 1'b0;
      r_col      <= '0;
      r_col_full <= 1'b0;
    end else begin
      r_href_d <= i_href;
      if (w_href_fall) begin
        r_col      <= '0;
        r_col_full <= 1'b0;
      end else if (w_acc) begin
        if (r_col == LB_AW'(IMG_HDISP - 1)) begin
          r_col_full <= 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_row <= '0;
    end else if (!i_vsync) begin
      r_row <= '0;
    end else if (w_href_fall && (r_row != ROW_W'(IMG_VDISP - 1))) begin
      r_row <= r_row + 1'b1;
    end
  end

  // Line buffers: no reset, stale contents are masked by the border flag.
  always_ff @(posedge sys_clk) begin
    if (w_lb_we) begin
      r_lb1[r_col] <= w_lb0_rd;
      r_lb0[r_col] <= i_y;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_win    <= '0;
      r_acc    <= 1'b0;
      r_border <= 1'b0;
    end else begin
      r_acc <= w_acc;
      if (w_acc) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_lb1_rd;
        r_win[1][2] <= w_lb0_rd;
        r_win[2][2] <= i_y;
        r_border    <= (r_col < LB_AW'(2)) | (r_row < ROW_W'(2)) | r_col_full;
      end
    end
  end

  assign o_win    = r_win;
  assign o_acc    = r_acc;
  assign o_border = r_border;

endmodule

// File: rtl/gray_sobel_edge.sv
// Sobel edge detector on the luma of a 24-bit pixel stream.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   vip (slave)        : input timing/pixel/threshold, output timing/edge data
// Output timing is the input timing delayed SOBEL_LAT cycles; edge_data = {E,E,E}.
// Stages: S1 window (matrix), S2 Gx/Gy, S3 |Gx|+|Gy|, S4 decision.
// Build option SOBEL_MAG_OUT_EN: E is the magnitude saturated to 8 bits instead of a
// thresholded 00/FF; edge_thresh is then ignored.
module gray_sobel_edge
  import gray_sobel_edge_pkg::*;
#(
  parameter int unsigned IMG_HDISP = IMG_HDISP_DEF,
  parameter int unsigned IMG_VDISP = IMG_VDISP_DEF,
  parameter int unsigned LB_AW     = 10
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  gray_sobel_edge_if.slave  vip
);

  localparam int unsigned SUM_W = MAG_W - 1;

  timing_t                  w_tin;
  timing_t [SOBEL_LAT-1:0]  r_tdly;
  win_t                     w_win;
  logic                     w_vld1;
  logic                     w_bdr1;
  logic [SUM_W-1:0]         w_gx_p, w_gx_n, w_gy_p, w_gy_n;
  logic signed [MAG_W-1:0]  r_gx, r_gy;
  logic                     r_vld2, r_bdr2, r_vld3, r_bdr3;
  logic [MAG_W-1:0]         r_mag;
  logic [PIX_W-1:0]         w_e;
  logic [RGB_W-1:0]         r_edge;
  logic                     w_unused_cbcr;

  assign w_unused_cbcr = ^vip.pix_data_in[15:0];

  assign w_tin = '{vsync: vip.per_frame_vsync, href: vip.per_frame_href,
                   clken: vip.per_frame_clken};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tdly <= '0;
    end else begin
      r_tdly <= {r_tdly[SOBEL_LAT-2:0], w_tin};
    end
  end

  gray_sobel_edge_matrix #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP),
    .LB_AW     (LB_AW)
  ) u_matrix (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_vsync   (vip.per_frame_vsync),
    .i_href    (vip.per_frame_href),
    .i_clken   (vip.per_frame_clken),
    .i_y       (vip.pix_data_in[23:16]),
    .o_win     (w_win),
    .o_acc     (w_vld1),
    .o_border  (w_bdr1)
  );

  // Column/row weighted sums, each at most 4*255 = 1020.
  assign w_gx_p = SUM_W'(w_win[0][2]) + {1'b0, w_win[1][2], 1'b0} + SUM_W'(w_win[2][2]);
  assign w_gx_n = SUM_W'(w_win[0][0]) + {1'b0, w_win[1][0], 1'b0} + SUM_W'(w_win[2][0]);
  assign w_gy_p = SUM_W'(w_win[2][0]) + {1'b0, w_win[2][1], 1'b0} + SUM_W'(w_win[2][2]);
  assign w_gy_n = SUM_W'(w_win[0][0]) + {1'b0, w_win[0][1], 1'b0} + SUM_W'(w_win[0][2]);

`ifdef SOBEL_MAG_OUT_EN
  logic w_unused_thr;
  assign w_unused_thr = ^vip.edge_thresh;

  always_comb begin
    w_e = '0;
    w_e = (r_mag > MAG_W'(255)) ? 8'hFF : r_mag[7:0];
  end
`else
  // Threshold travels with its pixel so a mid-frame change only affects later pixels.
  logic [MAG_W-1:0] r_thr1, r_thr2, r_thr3;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_thr1 <= '0;
      r_thr2 <= '0;
      r_thr3 <= '0;
    end else begin
      if (vip.per_frame_href && vip.per_frame_clken) begin
        r_thr1 <= vip.edge_thresh;
      end
      r_thr2 <= r_thr1;
      r_thr3 <= r_thr2;
    end
  end

  always_comb begin
    w_e = '0;
    w_e = (r_mag > r_thr3) ? 8'hFF : 8'h00;
  end
`endif

  // S2..S4 run every cycle; the valid bits keep them aligned with the timing delay line.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_gx   <= '0;
      r_gy   <= '0;
      r_vld2 <= 1'b0;
      r_bdr2 <= 1'b0;
      r_mag  <= '0;
      r_vld3 <= 1'b0;
      r_bdr3 <= 1'b0;
      r_edge <= '0;
    end else begin
      r_gx   <= $signed({1'b0, w_gx_p}) - $signed({1'b0, w_gx_n});
      r_gy   <= $signed({1'b0, w_gy_p}) - $signed({1'b0, w_gy_n});
      r_vld2 <= w_vld1;
      r_bdr2 <= w_bdr1;
      r_mag  <= abs_mag(r_gx) + abs_mag(r_gy);
      r_vld3 <= r_vld2;
      r_bdr3 <= r_bdr2;
      r_edge <= (r_vld3 && !r_bdr3) ? {3{w_e}} : '0;
    end
  end

  assign vip.post_frame_vsync = r_tdly[SOBEL_LAT-1].vsync;
  assign vip.post_frame_href  = r_tdly[SOBEL_LAT-1].href;
  assign vip.post_frame_clken = r_tdly[SOBEL_LAT-1].clken;
  assign vip.edge_data        = r_edge;

endmodule

// File: doc/gray_sobel_edge.md
Name: gray_sobel_edge

Overview:
- Downstream stage of rgb2ycbcr. Consumes the 24-bit gray/YCbCr pixel stream and its post_frame_vsync/href/clken timing.
- Builds a 3x3 luma window using two line buffers and computes the Sobel gradient magnitude |Gx|+|Gy|.
- Outputs a binary edge map, replicated onto 24-bit RGB, with re-aligned frame timing. The result is written back to BMP by the bench capture logic.

Parameters:
- IMG_HDISP, 640, active pixels per line; also the line-buffer depth.
- IMG_VDISP, 480, active lines per frame; bounds the row counter.
- LB_AW, 10, line-buffer address width; requires 2^LB_AW >= IMG_HDISP.

Ports:
- sys_clk  in  1  system clock; the single clock domain.
- sys_rst_n  in  1  asynchronous active-low reset.
- per_frame_vsync  in  1  input vertical sync; low = sync interval, high = frame active.
- per_frame_href  in  1  input line-valid.
- per_frame_clken  in  1  input pixel strobe; pixel accepted only when href&clken.
- pix_data_in  in  24  input pixel; luma Y = pix_data_in[23:16].
- edge_thresh  in  11  magnitude threshold; sampled every accepted pixel.
- post_frame_vsync  out  1  vsync delayed by LAT.
- post_frame_href  out  1  href delayed by LAT.
- post_frame_clken  out  1  clken delayed by LAT.
- edge_data  out  24  {E,E,E}; E = 8'hFF edge, 8'h00 no edge.

Behaviour:
- Reset: all outputs 0; counters 0; window registers 0. Line-buffer contents are don't-care and are masked by the border rule.
- LAT = 4 cycles, fixed. Input href/clken/vsync at cycle n appear on outputs at n+4, including blanking. No other gaps or stretching.
- Accept condition: acc = per_frame_href & per_frame_clken. No state advances on non-accept cycles except the timing delay line.
- Column counter col (LB_AW bits): increments on acc; cleared on the falling edge of per_frame_href.
- Row counter row (11 bits): increments on the falling edge of href; cleared while per_frame_vsync == 0.
- Line buffers LB0/LB1, depth IMG_HDISP x 8. On acc at col c:
  - read LB1[c] -> row y-2 and LB0[c] -> row y-1;
  - write LB1[c] <= LB0[c] and LB0[c] <= Y.
  - Read-before-write at the same address.
- Window: 3 shift registers of 3 taps, shifted on acc only. The bottom-right tap is the current pixel (x,y); the center is (x-1,y-1).
- Pipeline:
  - S1: window shift and border flag capture.
  - S2: Gx = (p13+2*p23+p33)-(p11+2*p21+p31); Gy = (p31+2*p32+p33)-(p11+2*p12+p13). Signed 11-bit, range +/-1020.
  - S3: mag = |Gx|+|Gy|, unsigned 11-bit, max 2040, no overflow.
  - S4: E = (mag > edge_thresh) ? FF : 00. Strictly greater.
- Border rule: border = (col < 2) | (row < 2), captured with the pixel. If border, E = 00 regardless of mag.
- Pixels beyond IMG_HDISP in a line (malformed input): col saturates at IMG_HDISP-1, no address wrap, and the pixel forces E = 00.
- edge_thresh changes mid-frame take effect on the next accepted pixel's S4 compare; no glitch on others.
- Reset mid-frame: immediate clear. The partial frame resumes with row=0, so its first 2 rows out are 0. The next vsync low re-aligns.
- A vsync drop mid-line clears row only; col clears at the href fall.

Optional Feature:
- Macro: SOBEL_MAG_OUT_EN.
- Defined: E = border ? 00 : (mag > 255 ? 8'hFF : mag[7:0]). Saturated grey-level magnitude; edge_thresh ignored but port kept. LAT unchanged.
- Undefined: binary threshold output as above.

Decomposition:
- Shared package vip_pkg: IMG_HDISP/IMG_VDISP defaults, PIX_W=8, RGB_W=24, SOBEL_LAT=4, MAG_W=11.
- Sub-module vip_matrix_3x3:
  - contains the two line buffers, col/row counters, window taps and border flag;
  - outputs nine 8-bit taps plus the delayed acc and border flag;
  - reused later by median/erosion stages.
- gray_sobel_edge instantiates it and holds the S2-S4 arithmetic and the timing delay line.

Test Plan:
- Uniform frame Y=0x80 (640x480, edge_thresh=0) -> every edge_data=0; output timing equals input timing shifted exactly 4 cycles.
- Vertical step: Y=0 for x<320, Y=255 otherwise; edge_thresh=100. Rows >=2 with window center x=319,320 (i.e. input x=320,321) -> mag=1020, FFFFFF; all else 0.
- Horizontal step at y=240 (Y=0 above, 255 below; edge_thresh=1019) -> edge rows 00FFFFFF at input y=240,241 only for col>=2. edge_thresh=1020 -> all 0, confirming strict compare.
- Border: random image -> every output from input col 0,1 or row 0,1 is 000000.
- Reset asserted at row 100, col 50, released 3 cycles later -> outputs 0 immediately. Next lines treated as rows 0,1 (all 0) until vsync low; following frame matches golden model bit-exact.
- SOBEL_MAG_OUT_EN build with step 0->40 -> center pixels output 0xA0 (mag=160); step 0->255 -> saturated 0xFF.
